record_serializer: RTL and testbench

- Sits downstream of the record FIFO in the fx2_clk domain.
- Pops 48-bit timetag records from the show-ahead FIFO read port and emits them to the FX2 data endpoint as bytes, one byte per host handshake, least-significant byte first.
- Holds one record in reserve behind the record being serialised, so the host sees back-to-back bytes across record boundaries.
- Counts completed records for the register framework.

---
 rtl/record_serializer_if.sv | 44 ++++
 rtl/record_serializer.sv | 139 +++++++++++++
 tb/tb_record_serializer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/record_serializer_if.sv
// ---------------------------------------------------------------------------
// record_serializer_if
//   Groups the record FIFO read port and the FX2 byte endpoint that
//   record_serializer sits between.
//
//   FIFO side (show-ahead read port):
//     sample_rdy  FIFO not empty, sample is valid
//     sample      FIFO head record, REC_WIDTH bits
//     sample_req  pop strobe (FIFO rdreq)
//   Host side (FX2 data endpoint):
//     data_rdy    data holds a valid byte
//     data        current byte
//     data_ack    one-cycle pulse: host consumed the current byte
//
//   master: the serializer.  slave: the FIFO/host environment.
// ---------------------------------------------------------------------------
interface record_serializer_if #(
  parameter int REC_WIDTH = 48
);
  logic                 sample_rdy;
  logic [REC_WIDTH-1:0] sample;
  logic                 sample_req;
  logic                 data_rdy;
  logic [7:0]           data;
  logic                 data_ack;

  modport master (
    input  sample_rdy,
    input  sample,
    input  data_ack,
    output sample_req,
    output data_rdy,
    output data
  );

  modport slave (
    output sample_rdy,
    output sample,
    output data_ack,
    input  sample_req,
    input  data_rdy,
    input  data
  );
endinterface

// File: rtl/record_serializer.sv
// ---------------------------------------------------------------------------
// record_serializer
//   Pops fixed-width timetag records from a show-ahead FIFO and hands them
//   to the FX2 data endpoint one byte per host ack.  A hold register keeps
//   one record in reserve so the byte stream has no bubble across record
//   boundaries.  Completed records are counted for the register framework.
//
// Ports:
//   clk           fx2_clk domain clock
//   reset         asynchronous, active-high reset
//   enable        low: no new pops; held/in-flight records still drain
//   bus           record_serializer_if.master (FIFO read port + byte endpoint)
//   records_sent  records whose last byte was acked (wraps)
//   busy          shifter or hold register occupied
//
// Parameters:
//   REC_WIDTH     record width in bits, multiple of 8
//   MSB_FIRST     0: byte 0 = rec[7:0]; 1: byte 0 = rec[REC_WIDTH-1 -: 8]
// ---------------------------------------------------------------------------
module record_serializer #(
  parameter int REC_WIDTH = 48,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  record_serializer_if.master  bus,
  output logic [31:0]          records_sent,
  output logic                 busy
);

  localparam int NBYTES = REC_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  // Shifter: record currently on the byte endpoint.
  logic [REC_WIDTH-1:0] sh_q, sh_d;
  logic                 sh_valid_q, sh_valid_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  // Hold register: next record, waiting for the shifter.
  logic [REC_WIDTH-1:0] hd_q, hd_d;
  logic                 hd_valid_q, hd_valid_d;

  logic [31:0]          cnt_q, cnt_d;
  logic [7:0]           data_q, data_d;

  logic                 pop;
  logic                 ack;
  logic                 last_ack;
  logic [7:0]           byte_d [NBYTES];

  // A pop is only allowed while the hold register is free, so a pop and a
  // hold-to-shifter transfer never target the shifter in the same cycle.
  assign pop      = bus.sample_rdy & enable & ~hd_valid_q & ~reset;
  assign ack      = bus.data_ack & sh_valid_q;
  assign last_ack = ack & (idx_q == IDX_LAST);

  always_comb begin
    sh_d       = sh_q;
    sh_valid_d = sh_valid_q;
    idx_d      = idx_q;
    hd_d       = hd_q;
    hd_valid_d = hd_valid_q;
    cnt_d      = cnt_q;

    if (ack && !last_ack) begin
      idx_d = idx_q + IDX_W'(1);
    end

    if (last_ack) begin
      cnt_d      = cnt_q + 32'd1;
      sh_valid_d = 1'b0;
      if (hd_valid_q) begin
        sh_d       = hd_q;
        sh_valid_d = 1'b1;
        idx_d      = '0;
        hd_valid_d = 1'b0;
      end
    end

    if (pop) begin
      // Shifter is free now (empty or finishing this cycle): load it
      // directly; otherwise park the record in the hold register.
      if (!sh_valid_q || last_ack) begin
        sh_d       = bus.sample;
        sh_valid_d = 1'b1;
        idx_d      = '0;
      end else begin
        hd_d       = bus.sample;
        hd_valid_d = 1'b1;
      end
    end
  end

  // Byte lanes of the next shifter contents, in transmit order.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    if (MSB_FIRST) begin : g_msb
      assign byte_d[gi] = sh_d[REC_WIDTH-1-8*gi -: 8];
    end else begin : g_lsb
      assign byte_d[gi] = sh_d[8*gi +: 8];
    end
  end

  // The output byte is registered from next-state so it lines up with
  // data_rdy; with the shifter empty the last byte is simply held.
  always_comb begin
    data_d = data_q;
    if (sh_valid_d) begin
      data_d = byte_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q       <= '0;
      sh_valid_q <= 1'b0;
      idx_q      <= '0;
      hd_q       <= '0;
      hd_valid_q <= 1'b0;
      cnt_q      <= '0;
      data_q     <= 8'h00;
    end else begin
      sh_q       <= sh_d;
      sh_valid_q <= sh_valid_d;
      idx_q      <= idx_d;
      hd_q       <= hd_d;
      hd_valid_q <= hd_valid_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
    end
  end

  assign bus.sample_req = pop;
  assign bus.data_rdy   = sh_valid_q;
  assign bus.data       = data_q;
  assign records_sent   = cnt_q;
  assign busy           = sh_valid_q | hd_valid_q;

endmodule

// File: tb/tb_record_serializer.sv
`timescale 1ns/1ps
module tb_record_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] sent_a, sent_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  record_serializer_if #(.REC_WIDTH(48)) bus_a ();
  record_serializer_if #(.REC_WIDTH(48)) bus_b ();

  record_serializer #(.REC_WIDTH(48), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus_a),
    .records_sent(sent_a), .busy(busy_a)
  );

  record_serializer #(.REC_WIDTH(48), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus_b),
    .records_sent(sent_b), .busy(busy_b)
  );

  // Show-ahead FIFO models: written by the stimulus, popped on sample_req.
  logic [47:0] mem_a [16];
  logic [47:0] mem_b [16];
  int wr_a = 0, rd_a = 0, pops_a = 0;
  int wr_b = 0, rd_b = 0, pops_b = 0;

  assign bus_a.sample_rdy = (wr_a != rd_a);
  assign bus_a.sample     = mem_a[rd_a[3:0]];
  assign bus_b.sample_rdy = (wr_b != rd_b);
  assign bus_b.sample     = mem_b[rd_b[3:0]];

  always @(posedge clk) begin
    if (bus_a.sample_req) begin
      rd_a   <= rd_a + 1;
      pops_a <= pops_a + 1;
    end
    if (bus_b.sample_req) begin
      rd_b   <= rd_b + 1;
      pops_b <= pops_b + 1;
    end
  end

  // Scoreboards: expected bytes in host order.
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int checks = 0;
  int errors = 0;
  int p0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_a(input logic [47:0] rec);
    mem_a[wr_a[3:0]] = rec;
    wr_a++;
    for (int k = 0; k < 6; k++) exp_a.push_back(rec[8*k +: 8]);
  endtask

  task automatic push_b(input logic [47:0] rec);
    mem_b[wr_b[3:0]] = rec;
    wr_b++;
    for (int k = 0; k < 6; k++) exp_b.push_back(rec[47-8*k -: 8]);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_a.delete();
    exp_b.delete();
    cyc(2);
    reset = 1'b0;
  endtask

  // Monitor: every accepted byte is popped from its scoreboard and compared.
  task automatic monitor();
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (bus_a.data_rdy && bus_a.data_ack) begin
          if (exp_a.size() == 0) chk("a_extra_byte", 64'd1, 64'd0);
          else chk("a_byte", 64'(bus_a.data), 64'(exp_a.pop_front()));
        end
        if (bus_b.data_rdy && bus_b.data_ack) begin
          if (exp_b.size() == 0) chk("b_extra_byte", 64'd1, 64'd0);
          else chk("b_byte", 64'(bus_b.data), 64'(exp_b.pop_front()));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    bus_a.data_ack = 1'b0;
    bus_b.data_ack = 1'b0;
    fork
      monitor();
    join_none

    // Reset values, and no pop while reset is high even with a record ready.
    cyc(2);
    push_a(48'h0605_0403_0201);
    #1;
    chk("rst_data_rdy", 64'(bus_a.data_rdy), 64'd0);
    chk("rst_data", 64'(bus_a.data), 64'h00);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_sent", 64'(sent_a), 64'd0);
    chk("rst_sample_req", 64'(bus_a.sample_req), 64'd0);

    // Single record, ack every cycle: 01..06 LSB first.
    @(negedge clk);
    reset = 1'b0;
    bus_a.data_ack = 1'b1;
    cyc(10);
    #1;
    chk("t1_pops", 64'(pops_a), 64'd1);
    chk("t1_sent", 64'(sent_a), 64'd1);
    chk("t1_data_rdy", 64'(bus_a.data_rdy), 64'd0);
    chk("t1_busy", 64'(busy_a), 64'd0);
    chk("t1_data_hold", 64'(bus_a.data), 64'h06);

    // Two records back to back: data_rdy must stay high for all 12 bytes.
    do_reset();
    p0 = pops_a;
    push_a(48'h1111_1111_11AA);
    push_a(48'h2222_2222_22BB);
    cyc(1);
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("t2_no_gap", 64'(bus_a.data_rdy), 64'd1);
      @(negedge clk);
    end
    cyc(3);
    #1;
    chk("t2_pops", 64'(pops_a - p0), 64'd2);
    chk("t2_sent", 64'(sent_a), 64'd2);
    chk("t2_data_rdy", 64'(bus_a.data_rdy), 64'd0);

    // Host stall with three records queued: only shifter + hold fill.
    do_reset();
    bus_a.data_ack = 1'b0;
    p0 = pops_a;
    push_a(48'h3333_3333_3301);
    push_a(48'h4444_4444_4402);
    push_a(48'h5555_5555_5503);
    cyc(5);
    #1;
    chk("t3_stall_pops", 64'(pops_a - p0), 64'd2);
    chk("t3_stall_req", 64'(bus_a.sample_req), 64'd0);
    chk("t3_stall_busy", 64'(busy_a), 64'd1);
    chk("t3_stall_rdy", 64'(bus_a.data_rdy), 64'd1);
    @(negedge clk);
    bus_a.data_ack = 1'b1;
    // Hold is full through all six acks of record 1; it frees on the 6th
    // ack edge and the third pop follows in the next cycle.
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_req_low", 64'(bus_a.sample_req), 64'd0);
      @(negedge clk);
    end
    #1;
    chk("t3_req_high", 64'(bus_a.sample_req), 64'd1);
    chk("t3_pops_before", 64'(pops_a - p0), 64'd2);
    @(negedge clk);
    #1;
    chk("t3_pops_after", 64'(pops_a - p0), 64'd3);
    cyc(20);
    #1;
    chk("t3_sent", 64'(sent_a), 64'd3);
    chk("t3_busy", 64'(busy_a), 64'd0);

    // Spurious acks while idle, then enable low with a record waiting.
    @(negedge clk); bus_a.data_ack = 1'b0;
    @(negedge clk); bus_a.data_ack = 1'b1;
    @(negedge clk); bus_a.data_ack = 1'b0;
    @(negedge clk); bus_a.data_ack = 1'b1;
    @(negedge clk); bus_a.data_ack = 1'b0;
    #1;
    chk("t4_sent", 64'(sent_a), 64'd3);
    chk("t4_rdy", 64'(bus_a.data_rdy), 64'd0);
    @(negedge clk);
    enable = 1'b0;
    p0 = pops_a;
    push_a(48'hDEAD_BEEF_CAFE);
    cyc(5);
    #1;
    chk("t4_pops", 64'(pops_a - p0), 64'd0);
    chk("t4_req", 64'(bus_a.sample_req), 64'd0);
    chk("t4_rdy_off", 64'(bus_a.data_rdy), 64'd0);
    chk("t4_busy", 64'(busy_a), 64'd0);
    chk("t4_sent_off", 64'(sent_a), 64'd3);

    // Async reset after three bytes of a record.
    @(negedge clk);
    enable = 1'b1;
    cyc(1);
    bus_a.data_ack = 1'b1;
    cyc(3);
    bus_a.data_ack = 1'b0;
    #1;
    chk("t5_pre_data", 64'(bus_a.data), 64'hBE);
    chk("t5_pre_rdy", 64'(bus_a.data_rdy), 64'd1);
    #2;
    reset = 1'b1;
    exp_a.delete();
    exp_b.delete();
    #1;
    chk("t5_rdy", 64'(bus_a.data_rdy), 64'd0);
    chk("t5_data", 64'(bus_a.data), 64'h00);
    chk("t5_busy", 64'(busy_a), 64'd0);
    chk("t5_sent", 64'(sent_a), 64'd0);
    cyc(2);
    reset = 1'b0;

    // MSB-first instance: 06..01, then counter wrap from all-ones.
    @(negedge clk);
    push_b(48'h0605_0403_0201);
    bus_b.data_ack = 1'b1;
    cyc(10);
    #1;
    chk("t6_sent", 64'(sent_b), 64'd1);
    chk("t6_pops", 64'(pops_b), 64'd1);
    @(negedge clk);
    force dut_b.cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_b.cnt_q;
    #1;
    chk("t6_preload", 64'(sent_b), 64'hFFFF_FFFF);
    @(negedge clk);
    push_b(48'hA1A2_A3A4_A5A6);
    cyc(10);
    #1;
    chk("t6_wrap", 64'(sent_b), 64'd0);
    chk("t6_busy", 64'(busy_b), 64'd0);

    chk("a_all_bytes_seen", 64'(exp_a.size()), 64'd0);
    chk("b_all_bytes_seen", 64'(exp_b.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
